// File: rtl/ibex_multdiv_param.sv
// rtl/ibex_multdiv_param.sv - parametrised multi-cycle multiply/divide unit with valid/ready handshake
// Divider datapath is present only when MULTDIV_DIV_EN is defined.
module ibex_multdiv_param #(
  parameter int WIDTH      = 32,
  parameter int MULT_SLICE = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o
);
  localparam int AW = 2*WIDTH+2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LP_M_LAST = CW'(WIDTH/MULT_SLICE - 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV_ABS, DIV_COMP, DIV_FIX, DONE} state_e;

  state_e           r_state;
  logic             r_op_hi;
  logic             r_b_signed;
  logic [AW-1:0]    r_mcand;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;

  // Multiplicand shifts left one slice per cycle, so each partial product lands already aligned.
  logic          w_top_neg;
  logic [AW-1:0] w_slice;
  logic [AW-1:0] w_acc_nxt;
  assign w_top_neg = r_b_signed & (r_cnt == LP_M_LAST) & r_mplier[MULT_SLICE-1];
  assign w_slice   = {{(AW-MULT_SLICE){w_top_neg}}, r_mplier[MULT_SLICE-1:0]};
  assign w_acc_nxt = r_acc + r_mcand * w_slice;

`ifdef MULTDIV_DIV_EN
  localparam logic [WIDTH-1:0] LP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_a_signed;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_den;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;

  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_ovf;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  assign w_neg_a  = r_a_signed & r_mcand[WIDTH-1];
  assign w_neg_b  = r_b_signed & r_mplier[WIDTH-1];
  assign w_ovf    = r_a_signed & r_b_signed & (r_mcand[WIDTH-1:0] == LP_MIN) & (&r_mplier);
  assign w_rem_sh = {r_rem, r_num[r_cnt]};
  assign w_diff   = w_rem_sh - {1'b0, r_den};
  // A set top bit of the shifted remainder already exceeds any divisor; otherwise the borrow decides.
  assign w_ge     = w_rem_sh[WIDTH] | ~w_diff[WIDTH];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_op_hi    <= 1'b0;
      r_b_signed <= 1'b0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_mplier   <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
`ifdef MULTDIV_DIV_EN
      r_a_signed <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_num      <= '0;
      r_den      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
`endif
    end else if (kill_i && (r_state != IDLE)) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i && !kill_i) begin
            r_op_hi    <= operator_i[0];
            r_b_signed <= signed_mode_i[1];
            r_mcand    <= {{(AW-WIDTH){signed_mode_i[0] & op_a_i[WIDTH-1]}}, op_a_i};
            r_mplier   <= op_b_i;
            r_acc      <= '0;
            r_cnt      <= '0;
`ifdef MULTDIV_DIV_EN
            r_a_signed <= signed_mode_i[0];
`endif
            r_state    <= operator_i[1] ? DIV_ABS : MULT;
          end
        end
        MULT: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << MULT_SLICE;
          r_mplier <= r_mplier >> MULT_SLICE;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LP_M_LAST) begin
            r_result <= r_op_hi ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
            r_state  <= DONE;
          end
        end
`ifdef MULTDIV_DIV_EN
        DIV_ABS: begin
          if (r_mplier == '0) begin
            r_result <= r_op_hi ? r_mcand[WIDTH-1:0] : '1;
            r_state  <= DONE;
          end else if (w_ovf) begin
            r_result <= r_op_hi ? '0 : r_mcand[WIDTH-1:0];
            r_state  <= DONE;
          end else begin
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_num   <= w_neg_a ? -r_mcand[WIDTH-1:0] : r_mcand[WIDTH-1:0];
            r_den   <= w_neg_b ? -r_mplier : r_mplier;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= CW'(WIDTH-1);
            r_state <= DIV_COMP;
          end
        end
        DIV_COMP: begin
          if (w_ge) begin
            r_rem        <= w_diff[WIDTH-1:0];
            r_quo[r_cnt] <= 1'b1;
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= DIV_FIX;
        end
        DIV_FIX: begin
          r_result <= r_op_hi ? (r_neg_a ? -r_rem : r_rem)
                              : ((r_neg_a ^ r_neg_b) ? -r_quo : r_quo);
          r_state  <= DONE;
        end
`else
        DIV_ABS: begin
          r_result <= '0;
          r_state  <= DONE;
        end
`endif
        DONE: begin
          if (resp_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign resp_valid_o = (r_state == DONE);
  assign result_o     = r_result;
endmodule

// File: tb/tb_ibex_multdiv_param.sv
// tb/tb_ibex_multdiv_param.sv - randomized bench for ibex_multdiv_param against an arithmetic model
// Expectations follow MULTDIV_DIV_EN the same way the design does.
module tb_ibex_multdiv_param;
  localparam int W = 32;
  localparam int S = 16;
  localparam int N = W / S;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    operator_i = 2'd0;
  logic [1:0]    signed_mode_i = 2'd0;
  logic [W-1:0]  op_a_i = '0;
  logic [W-1:0]  op_b_i = '0;
  logic          kill_i = 1'b0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b1;
  logic [W-1:0]  result_o;

  always #5 clk_i = ~clk_i;

  ibex_multdiv_param #(.WIDTH(W), .MULT_SLICE(S)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .operator_i(operator_i), .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .kill_i(kill_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .result_o(result_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Reference: true-integer product/quotient, truncated to W bits.
  function automatic void model(input logic [1:0] op, input logic [1:0] mode,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    longint av, bv, p;
    av = mode[0] ? {{32{a[31]}}, a} : {32'b0, a};
    bv = mode[1] ? {{32{b[31]}}, b} : {32'b0, b};
    if (!op[1]) begin
      p   = av * bv;
      res = op[0] ? p[63:32] : p[31:0];
      lat = N;
    end else begin
`ifdef MULTDIV_DIV_EN
      longint q, r;
      if (b == 32'd0) begin
        res = op[0] ? a : 32'hFFFF_FFFF;
        lat = 1;
      end else if (mode == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res = op[0] ? 32'd0 : a;
        lat = 1;
      end else begin
        q   = av / bv;
        r   = av % bv;
        res = op[0] ? r[31:0] : q[31:0];
        lat = W + 2;
      end
`else
      res = 32'd0;
      lat = 1;
`endif
    end
  endfunction

  // Cycle-level monitor: one outstanding transaction, visible lat cycles after accept.
  int          cyc = 0;
  int          n_resp = 0;
  bit          pend = 1'b0;
  bit          m_ev;
  int          t_done = 0;
  int          m_lat;
  logic [31:0] m_res = '0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      pend = 1'b0;
      check("rst_req_ready", req_ready_o, 1);
      check("rst_resp_valid", resp_valid_o, 0);
      check("rst_result", result_o, 0);
    end else begin
      m_ev = pend && (cyc >= t_done);
      check("req_ready", req_ready_o, !pend);
      check("resp_valid", resp_valid_o, m_ev);
      if (m_ev) check("result", result_o, m_res);
      if (pend) begin
        if (kill_i) pend = 1'b0;
        else if (m_ev && resp_ready_i) begin
          pend = 1'b0;
          n_resp++;
        end
      end else if (req_valid_i && !kill_i) begin
        model(operator_i, signed_mode_i, op_a_i, op_b_i, m_res, m_lat);
        pend   = 1'b1;
        t_done = cyc + m_lat + 1;
      end
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (!req_ready_o && g < 100) begin
      @(posedge clk_i); #1;
      g++;
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        output logic [31:0] res, output int lat, output bit got);
    wait_idle();
    resp_ready_i  = (hold == 0);
    operator_i    = op;
    signed_mode_i = mode;
    op_a_i        = a;
    op_b_i        = b;
    req_valid_i   = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i   = 1'b0;
    operator_i    = 2'($urandom);
    signed_mode_i = 2'($urandom);
    op_a_i        = $urandom;
    op_b_i        = $urandom;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
      got = resp_valid_o;
    end
    res = result_o;
    repeat (hold) begin
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          hold;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    logic [1:0]  op, mode;
    logic [31:0] a, b, res, er;
    int          lat, el, n0, n_done, ka, g;
    bit          got;

    vecs[0]  = '{2'd0, 2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, N, 0};
    vecs[1]  = '{2'd1, 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, N, 0};
    vecs[2]  = '{2'd1, 2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, N, 0};
    vecs[3]  = '{2'd1, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, N, 0};
    vecs[4]  = '{2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, W + 2, 0};
    vecs[5]  = '{2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, W + 2, 0};
    vecs[6]  = '{2'd2, 2'b00, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0};
    vecs[7]  = '{2'd3, 2'b00, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1, 0};
    vecs[8]  = '{2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0};
    vecs[9]  = '{2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0};
    vecs[10] = '{2'd0, 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, N, 5};
    n_done = 0;

    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      er = vecs[i].res;
      el = vecs[i].lat;
`ifndef MULTDIV_DIV_EN
      if (vecs[i].op[1]) begin
        er = 32'd0;
        el = 1;
      end
`endif
      model(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("model_res[%0d]", i), res, er);
      check($sformatf("model_lat[%0d]", i), lat, el);
      n0 = n_resp;
      do_req(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].hold, res, lat, got);
      n_done += int'(got);
      check($sformatf("dir_got[%0d]", i), got, 1);
      check($sformatf("dir_res[%0d]", i), res, er);
      check($sformatf("dir_lat[%0d]", i), lat, el);
      check($sformatf("dir_one_resp[%0d]", i), n_resp - n0, 1);
    end

    // kill in IDLE must block the accept
    wait_idle();
    operator_i  = 2'd0;
    req_valid_i = 1'b1;
    kill_i      = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    kill_i      = 1'b0;
    check("kill_idle_ready", req_ready_o, 1);

    // kill mid-operation
`ifdef MULTDIV_DIV_EN
    op = 2'd2; ka = 10;
`else
    op = 2'd0; ka = 1;
`endif
    wait_idle();
    n0 = n_resp;
    operator_i = op; signed_mode_i = 2'b11; op_a_i = 32'hFFFF_FF9C; op_b_i = 32'd7;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (ka) begin
      @(posedge clk_i); #1;
    end
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill_mid_ready", req_ready_o, 1);
    check("kill_mid_valid", resp_valid_o, 0);
    repeat (3) @(posedge clk_i);
    #1 check("kill_mid_no_resp", n_resp - n0, 0);
    do_req(2'd0, 2'b00, 32'd3, 32'd4, 0, res, lat, got);
    n_done += int'(got);
    check("after_kill_mull", res, 32'd12);

    // kill while DONE drops the held response
    wait_idle();
    n0 = n_resp;
    resp_ready_i = 1'b0;
    operator_i = 2'd0; signed_mode_i = 2'b00; op_a_i = 32'd9; op_b_i = 32'd9;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    g = 0;
    while (!resp_valid_o && g < 50) begin
      @(posedge clk_i); #1;
      g++;
    end
    check("done_reached", resp_valid_o, 1);
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    resp_ready_i = 1'b1;
    check("kill_done_valid", resp_valid_o, 0);
    check("kill_done_no_resp", n_resp - n0, 0);

    // asynchronous reset in the middle of a multiply
    wait_idle();
    operator_i = 2'd0; signed_mode_i = 2'b00; op_a_i = 32'h1234; op_b_i = 32'h5678;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", req_ready_o, 1);
    check("mid_rst_valid", resp_valid_o, 0);
    check("mid_rst_result", result_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 80; i++) begin
      op   = 2'($urandom);
      mode = 2'($urandom);
      a    = $urandom;
      b    = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; mode = 2'b11; end
        2: begin
          a = 32'($urandom_range(0, 40));
          b = 32'($urandom_range(0, 9));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      model(op, mode, a, b, er, el);
      do_req(op, mode, a, b, $urandom_range(0, 3), res, lat, got);
      n_done += int'(got);
      check($sformatf("rand_got[%0d]", i), got, 1);
      check($sformatf("rand_lat[%0d]", i), lat, el);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_i);
      #1;
    end

    repeat (2) @(posedge clk_i);
    #1 check("resp_count", n_resp, n_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
